// File: rtl/nvdla_dbb_axi_pkg.sv
// Shared definitions for the NVDLA DBB/CVSRAM AXI responder.
//   BEAT_SIZE  : AXI size encoding of the fixed 32-byte beat
//   BEAT_BYTES : bytes per beat (low address bits ignored)
//   CNT_W      : width of the burst length / beat counters
//   w_state_e  : write channel FSM states
//   r_state_e  : read channel FSM states
package nvdla_dbb_axi_pkg;

    localparam logic [2:0] BEAT_SIZE  = 3'b101;
    localparam int         BEAT_BYTES = 32;
    localparam int         CNT_W      = 4;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/nvdla_dbb_axi_mem.sv
// Backing store for the responder: DEPTH words of DATA_W bits.
//   clk     : clock
//   wr_en   : write enable; wr_strb selects which bytes of word wr_idx are written
//   wr_idx  : write word index
//   wr_strb : byte enables
//   wr_data : write data
//   rd_en   : load rd_data with word rd_idx at the next clock edge
//   rd_idx  : read word index
//   rd_data : registered read data (holds while rd_en is low)
// Contents and the read register are deliberately not reset.
module nvdla_dbb_axi_mem #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 256
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [DATA_W/8-1:0]      wr_strb,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read and write share one edge, so a read of a word being written in the
    // same cycle returns the old contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/nvdla_dbb_axi_responder.sv
// AXI responder for the NVDLA DBB/CVSRAM memory port, backed by an internal
// DEPTH x DATA_W memory. Write and read channels run independently, one burst
// each at a time, INCR bursts of fixed 32-byte beats, no BRESP/RRESP.
//   core_clk, rstn       : clock, asynchronous active-low reset
//   aw_* / w_* / b_*     : write address, write data, write response channels
//   ar_* / r_*           : read address and read data channels
// Word index is addr[5 +: log2(DEPTH)]; higher address bits alias.
module nvdla_dbb_axi_responder
    import nvdla_dbb_axi_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 256,
    parameter int ID_W   = 8
) (
    input  logic                core_clk,
    input  logic                rstn,
    input  logic                aw_awvalid,
    output logic                aw_awready,
    input  logic [ID_W-1:0]     aw_awid,
    input  logic [CNT_W-1:0]    aw_awlen,
    input  logic [2:0]          aw_awsize,
    input  logic [ADDR_W-1:0]   aw_awaddr,
    input  logic                w_wvalid,
    output logic                w_wready,
    input  logic [DATA_W-1:0]   w_wdata,
    input  logic [DATA_W/8-1:0] w_wstrb,
    input  logic                w_wlast,
    output logic                b_bvalid,
    input  logic                b_bready,
    output logic [ID_W-1:0]     b_bid,
    input  logic                ar_arvalid,
    output logic                ar_arready,
    input  logic [ID_W-1:0]     ar_arid,
    input  logic [CNT_W-1:0]    ar_arlen,
    input  logic [2:0]          ar_arsize,
    input  logic [ADDR_W-1:0]   ar_araddr,
    output logic                r_rvalid,
    input  logic                r_rready,
    output logic [ID_W-1:0]     r_rid,
    output logic                r_rlast,
    output logic [DATA_W-1:0]   r_rdata
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(BEAT_BYTES);
    localparam logic [IDX_W-1:0] IDX_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Size and wlast carry no information here: beats are fixed and the
    // burst length comes from awlen.
    logic unused_inputs;
    assign unused_inputs = ^{aw_awsize, ar_arsize, w_wlast, aw_awaddr, ar_araddr};

    // Ready signals stay low until the first clock edge after reset release.
    logic live;
    always_ff @(posedge core_clk or negedge rstn) begin
        if (!rstn) live <= 1'b0;
        else       live <= 1'b1;
    end

    w_state_e         w_state, w_state_nxt;
    logic [IDX_W-1:0] w_idx;
    logic [CNT_W-1:0] w_cnt, w_len;
    logic [ID_W-1:0]  w_id;
    logic             aw_hs, w_hs;

    r_state_e         r_state, r_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt, r_len;
    logic [ID_W-1:0]  r_id;
    logic             ar_hs, r_hs, r_last_beat;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [DATA_W-1:0] rd_data;

    always_ff @(posedge core_clk or negedge rstn) begin
        if (!rstn) w_state <= W_IDLE;
        else       w_state <= w_state_nxt;
    end

    // The beat counter, not wlast, decides when the burst is complete.
    always_comb begin
        w_state_nxt = w_state;
        aw_awready  = 1'b0;
        w_wready    = 1'b0;
        b_bvalid    = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_awready = live;
                if (aw_awvalid && live) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                w_wready = 1'b1;
                if (w_wvalid && (w_cnt == w_len)) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                b_bvalid = 1'b1;
                if (b_bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign aw_hs = aw_awvalid & aw_awready;
    assign w_hs  = w_wvalid & w_wready;
    assign b_bid = w_id;

    always_ff @(posedge core_clk or negedge rstn) begin
        if (!rstn) begin
            w_id  <= '0;
            w_idx <= '0;
            w_len <= '0;
            w_cnt <= '0;
        end else if (aw_hs) begin
            w_id  <= aw_awid;
            w_idx <= aw_awaddr[OFF_W +: IDX_W];
            w_len <= aw_awlen;
            w_cnt <= '0;
        end else if (w_hs) begin
            w_idx <= w_idx + IDX_ONE;
            w_cnt <= w_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge core_clk or negedge rstn) begin
        if (!rstn) r_state <= R_IDLE;
        else       r_state <= r_state_nxt;
    end

    // The first beat is loaded on AR accept; every non-final R handshake
    // prefetches the next word so beats can stream without bubbles.
    always_comb begin
        r_state_nxt = r_state;
        ar_arready  = 1'b0;
        r_rvalid    = 1'b0;
        rd_en       = 1'b0;
        rd_idx      = r_idx + IDX_ONE;
        case (r_state)
            R_IDLE: begin
                ar_arready = live;
                rd_idx     = ar_araddr[OFF_W +: IDX_W];
                if (ar_arvalid && live) begin
                    rd_en       = 1'b1;
                    r_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                r_rvalid = 1'b1;
                if (r_rready) begin
                    if (r_last_beat) r_state_nxt = R_IDLE;
                    else             rd_en       = 1'b1;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign ar_hs       = ar_arvalid & ar_arready;
    assign r_hs        = r_rvalid & r_rready;
    assign r_last_beat = (r_cnt == r_len);
    assign r_rlast     = r_rvalid & r_last_beat;
    assign r_rid       = r_id;
    // Masking with rvalid forces rdata to zero in reset and between bursts,
    // since the memory read register itself is never reset.
    assign r_rdata     = r_rvalid ? rd_data : '0;

    always_ff @(posedge core_clk or negedge rstn) begin
        if (!rstn) begin
            r_id  <= '0;
            r_idx <= '0;
            r_len <= '0;
            r_cnt <= '0;
        end else if (ar_hs) begin
            r_id  <= ar_arid;
            r_idx <= ar_araddr[OFF_W +: IDX_W];
            r_len <= ar_arlen;
            r_cnt <= '0;
        end else if (r_hs && !r_last_beat) begin
            r_idx <= r_idx + IDX_ONE;
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    nvdla_dbb_axi_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (core_clk),
        .wr_en   (w_hs),
        .wr_idx  (w_idx),
        .wr_strb (w_wstrb),
        .wr_data (w_wdata),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_nvdla_dbb_axi_responder.sv
// Self-checking bench for nvdla_dbb_axi_responder. Inputs are driven on the
// falling edge and outputs sampled there, away from the active rising edge.
// Read beats are predicted from a bench-side memory model and queued when the
// AR is issued; B ids are queued when the AW is issued.
module tb_nvdla_dbb_axi_responder;

    localparam int DEPTH = 1024;

    logic         core_clk = 1'b0;
    logic         rstn;
    logic         aw_awvalid, aw_awready;
    logic [7:0]   aw_awid;
    logic [3:0]   aw_awlen;
    logic [2:0]   aw_awsize;
    logic [63:0]  aw_awaddr;
    logic         w_wvalid, w_wready;
    logic [255:0] w_wdata;
    logic [31:0]  w_wstrb;
    logic         w_wlast;
    logic         b_bvalid, b_bready;
    logic [7:0]   b_bid;
    logic         ar_arvalid, ar_arready;
    logic [7:0]   ar_arid;
    logic [3:0]   ar_arlen;
    logic [2:0]   ar_arsize;
    logic [63:0]  ar_araddr;
    logic         r_rvalid, r_rready;
    logic [7:0]   r_rid;
    logic         r_rlast;
    logic [255:0] r_rdata;

    nvdla_dbb_axi_responder #(
        .DEPTH(DEPTH), .ADDR_W(64), .DATA_W(256), .ID_W(8)
    ) dut (
        .core_clk(core_clk), .rstn(rstn),
        .aw_awvalid(aw_awvalid), .aw_awready(aw_awready), .aw_awid(aw_awid),
        .aw_awlen(aw_awlen), .aw_awsize(aw_awsize), .aw_awaddr(aw_awaddr),
        .w_wvalid(w_wvalid), .w_wready(w_wready), .w_wdata(w_wdata),
        .w_wstrb(w_wstrb), .w_wlast(w_wlast),
        .b_bvalid(b_bvalid), .b_bready(b_bready), .b_bid(b_bid),
        .ar_arvalid(ar_arvalid), .ar_arready(ar_arready), .ar_arid(ar_arid),
        .ar_arlen(ar_arlen), .ar_arsize(ar_arsize), .ar_araddr(ar_araddr),
        .r_rvalid(r_rvalid), .r_rready(r_rready), .r_rid(r_rid),
        .r_rlast(r_rlast), .r_rdata(r_rdata)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        logic [255:0] data;
        logic [7:0]   id;
        logic         last;
    } rExp_t;

    rExp_t        rdQ[$];
    logic [7:0]   bidQ[$];
    logic [255:0] model [DEPTH];
    logic [255:0] wBuf [16];
    logic [31:0]  sBuf [16];
    int           checkCount = 0;
    int           passCount  = 0;

    task automatic checkOutput(input string tag, input logic [255:0] actual,
                               input logic [255:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        else
            passCount++;
    endtask

    function automatic int wordIndex(input logic [63:0] addr);
        return int'((addr >> 5) % DEPTH);
    endfunction

    task automatic modelWrite(input int idx, input logic [255:0] data, input logic [31:0] strb);
        for (int i = 0; i < 32; i++)
            if (strb[i]) model[idx][i*8 +: 8] = data[i*8 +: 8];
    endtask

    task automatic awSend(input logic [63:0] addr, input int len, input logic [7:0] id);
        int n = 0;
        aw_awaddr = addr; aw_awlen = 4'(len); aw_awid = id; aw_awsize = 3'b101;
        aw_awvalid = 1'b1;
        bidQ.push_back(id);
        while (!aw_awready && n < 100) begin @(negedge core_clk); n++; end
        if (!aw_awready) checkOutput("aw_timeout", 0, 1);
        @(negedge core_clk);
        aw_awvalid = 1'b0;
    endtask

    task automatic wSend(input logic [255:0] data, input logic [31:0] strb, input logic last);
        int n = 0;
        w_wdata = data; w_wstrb = strb; w_wlast = last; w_wvalid = 1'b1;
        while (!w_wready && n < 100) begin @(negedge core_clk); n++; end
        if (!w_wready) checkOutput("w_timeout", 0, 1);
        @(negedge core_clk);
        w_wvalid = 1'b0;
    endtask

    task automatic bReceive();
        int n = 0;
        b_bready = 1'b1;
        while (!b_bvalid && n < 100) begin @(negedge core_clk); n++; end
        if (!b_bvalid) checkOutput("b_timeout", 0, 1);
        checkOutput("bid", b_bid, bidQ.pop_front());
        @(negedge core_clk);
        b_bready = 1'b0;
    endtask

    task automatic writeBurst(input logic [63:0] addr, input int len, input logic [7:0] id);
        int idx = wordIndex(addr);
        awSend(addr, len, id);
        for (int k = 0; k <= len; k++) begin
            wSend(wBuf[k], sBuf[k], k == len);
            modelWrite((idx + k) % DEPTH, wBuf[k], sBuf[k]);
        end
        checkOutput("bvalid_rise", b_bvalid, 1);
        bReceive();
    endtask

    // Issues one AR and collects nBeats handshakes; rready toggles when asked.
    task automatic readBurst(input logic [63:0] addr, input int len, input logic [7:0] id,
                             input bit toggle, input int nBeats);
        int idx = wordIndex(addr);
        int n = 0, got = 0, cyc = 0;
        rExp_t e;
        for (int k = 0; k <= len; k++) begin
            e.data = model[(idx + k) % DEPTH]; e.id = id; e.last = (k == len);
            rdQ.push_back(e);
        end
        ar_araddr = addr; ar_arlen = 4'(len); ar_arid = id; ar_arsize = 3'b101;
        ar_arvalid = 1'b1;
        while (!ar_arready && n < 100) begin @(negedge core_clk); n++; end
        if (!ar_arready) checkOutput("ar_timeout", 0, 1);
        @(negedge core_clk);
        ar_arvalid = 1'b0;
        checkOutput("rvalid_rise", r_rvalid, 1);
        while (got < nBeats && cyc < 200) begin
            r_rready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (r_rvalid) begin
                if (rdQ.size() == 0) begin
                    checkOutput("rvalid_unexpected", r_rvalid, 0);
                end else begin
                    checkOutput("rdata", r_rdata, rdQ[0].data);
                    checkOutput("rid", r_rid, rdQ[0].id);
                    checkOutput("rlast", r_rlast, rdQ[0].last);
                    if (r_rready) begin void'(rdQ.pop_front()); got++; end
                end
            end
            @(negedge core_clk);
            cyc++;
        end
        r_rready = 1'b0;
        if (got < nBeats) checkOutput("r_timeout", got, nBeats);
    endtask

    task automatic applyStimulus();
        // Reset state
        rstn = 1'b0;
        aw_awvalid = 0; aw_awid = 0; aw_awlen = 0; aw_awsize = 0; aw_awaddr = 0;
        w_wvalid = 0; w_wdata = 0; w_wstrb = 0; w_wlast = 0; b_bready = 0;
        ar_arvalid = 0; ar_arid = 0; ar_arlen = 0; ar_arsize = 0; ar_araddr = 0;
        r_rready = 0;
        #1;
        checkOutput("rst_outs", {aw_awready, w_wready, b_bvalid, b_bid, ar_arready,
                                 r_rvalid, r_rid, r_rlast}, 0);
        checkOutput("rst_rdata", r_rdata, 0);
        repeat (3) @(negedge core_clk);
        rstn = 1'b1;
        #1 checkOutput("arready_pre_live", ar_arready, 0);
        @(negedge core_clk);
        checkOutput("arready_live", ar_arready, 1);
        checkOutput("awready_live", aw_awready, 1);

        // Single beat
        wBuf[0] = {8{32'hA5C3_0F1E}}; sBuf[0] = '1;
        writeBurst(64'h40, 0, 8'h12);
        readBurst(64'h40, 0, 8'h34, 1'b0, 1);

        // 16-beat burst, read back with rready toggling
        for (int k = 0; k < 16; k++) begin wBuf[k] = 256'(k); sBuf[k] = '1; end
        writeBurst(64'h1000, 15, 8'h21);
        readBurst(64'h1000, 15, 8'h22, 1'b1, 16);

        // Partial strobe
        wBuf[0] = '1; sBuf[0] = '1;
        writeBurst(64'h200, 0, 8'h31);
        wBuf[0] = '0; sBuf[0] = 32'h0000_000F;
        writeBurst(64'h200, 0, 8'h32);
        readBurst(64'h200, 0, 8'h33, 1'b0, 1);
        checkOutput("partial_model", model[16], {{28{8'hFF}}, 32'h0});

        // Wrap from the last word to word 0
        wBuf[0] = {4{64'h1111_2222_3333_4444}}; wBuf[1] = {4{64'h5555_6666_7777_8888}};
        sBuf[0] = '1; sBuf[1] = '1;
        writeBurst(64'h7FE0, 1, 8'h41);
        readBurst(64'h0, 0, 8'h42, 1'b0, 1);
        readBurst(64'h7FE0, 1, 8'h43, 1'b0, 2);

        // Write response backpressure with a second AW waiting
        wBuf[0] = {8{32'hBEEF_0001}}; sBuf[0] = '1;
        awSend(64'h500, 0, 8'h56);
        wSend(wBuf[0], sBuf[0], 1'b1);
        modelWrite(wordIndex(64'h500), wBuf[0], sBuf[0]);
        aw_awaddr = 64'h520; aw_awlen = 0; aw_awid = 8'h57; aw_awvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checkOutput("bp_bvalid", b_bvalid, 1);
            checkOutput("bp_bid", b_bid, 8'h56);
            checkOutput("bp_awready", aw_awready, 0);
            @(negedge core_clk);
        end
        bReceive();
        checkOutput("awready_after_b", aw_awready, 1);
        bidQ.push_back(8'h57);
        @(negedge core_clk);
        aw_awvalid = 1'b0;
        checkOutput("second_aw_taken", w_wready, 1);
        wBuf[0] = {8{32'hBEEF_0002}};
        wSend(wBuf[0], sBuf[0], 1'b1);
        modelWrite(wordIndex(64'h520), wBuf[0], sBuf[0]);
        checkOutput("bvalid_rise2", b_bvalid, 1);
        bReceive();
        readBurst(64'h500, 1, 8'h58, 1'b0, 2);

        // Reset during beat 3 of an 8-beat read
        for (int k = 0; k < 8; k++) begin wBuf[k] = {8{32'(k * 32'h0101_0101 + 32'h10)}}; sBuf[k] = '1; end
        writeBurst(64'h3000, 7, 8'h61);
        readBurst(64'h3000, 7, 8'h62, 1'b0, 3);
        checkOutput("beat3_stall", r_rdata, rdQ[0].data);
        #2 rstn = 1'b0;
        #1;
        checkOutput("midrst_outs", {aw_awready, w_wready, b_bvalid, ar_arready,
                                    r_rvalid, r_rlast}, 0);
        checkOutput("midrst_rdata", r_rdata, 0);
        rdQ.delete();
        @(negedge core_clk);
        rstn = 1'b1;
        #1 checkOutput("arready_pre_live2", ar_arready, 0);
        @(negedge core_clk);
        checkOutput("arready_live2", ar_arready, 1);
        readBurst(64'h3000, 7, 8'h63, 1'b0, 8);
        readBurst(64'h40, 0, 8'h64, 1'b0, 1);
    endtask

    initial begin
        applyStimulus();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
